// File: rtl/proc_pkg.sv
// Shared processor-datapath definitions: register file geometry and clear-engine states.
package proc_pkg;

    localparam int REG_W       = 32;
    localparam int REG_DEPTH   = 16;
    localparam int REG_ZERO    = 0;
    localparam int REG_ONE_IDX = 15;

    typedef enum logic {
        RF_RUN   = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of the multi-port register file.
// Priority: busy, zero reg, constant reg, port B bypass, port A bypass, stored value.
module regfile_rdport
    import proc_pkg::*;
#(
    parameter int              WIDTH     = REG_W,
    parameter int              AW        = 4,
    parameter int              CONST_EN  = 1,
    parameter int              CONST_IDX = REG_ONE_IDX,
    parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(1)
) (
    input  logic             busy,
    input  logic [AW-1:0]    addr,
    input  logic             wa_en,
    input  logic [AW-1:0]    wa_addr,
    input  logic [WIDTH-1:0] wa_data,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] data
);

    localparam logic [AW-1:0] ZERO_A  = AW'(REG_ZERO);
    localparam logic [AW-1:0] CONST_A = AW'(CONST_IDX);

    always_comb begin
        data = mem_data;
        if (busy) begin
            data = '0;
        end else if (addr == ZERO_A) begin
            data = '0;
        end else if ((CONST_EN != 0) && (addr == CONST_A)) begin
            data = CONST_VAL;
        end else if (wb_en && (wb_addr == addr)) begin
            data = wb_data;
        end else if (wa_en && (wa_addr == addr)) begin
            data = wa_data;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD read ports, two bypassed write ports (B wins),
// hardwired zero/constant registers and a sequenced clear sweep with a busy flag.
module regfile_mp
    import proc_pkg::*;
#(
    parameter int               WIDTH     = REG_W,
    parameter int               DEPTH     = REG_DEPTH,
    parameter int               NUM_RD    = 2,
    parameter int               CONST_EN  = 1,
    parameter int               CONST_IDX = REG_ONE_IDX,
    parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(1),
    localparam int              AW        = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_req,
    output logic                    clr_busy,
    input  logic                    wa_en,
    input  logic [AW-1:0]           wa_addr,
    input  logic [WIDTH-1:0]        wa_data,
    input  logic                    wb_en,
    input  logic [AW-1:0]           wb_addr,
    input  logic [WIDTH-1:0]        wb_data,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data
);

    // state    | meaning
    // RF_RUN   | normal operation: writes, bypass and reads active
    // RF_CLEAR | sweep zeroing mem[clr_idx] one entry per cycle; writes ignored, reads 0

    localparam logic [AW-1:0] ZERO_A  = AW'(REG_ZERO);
    localparam logic [AW-1:0] CONST_A = AW'(CONST_IDX);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

    rf_state_t        state;
    logic [AW-1:0]    clr_idx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wa_ok;
    logic             wb_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RF_CLEAR;
            clr_busy <= 1'b1;
            clr_idx  <= '0;
        end else begin
            case (state)
                RF_RUN: begin
                    if (clr_req) begin
                        state    <= RF_CLEAR;
                        clr_busy <= 1'b1;
                        clr_idx  <= '0;
                    end
                end
                RF_CLEAR: begin
                    clr_idx <= clr_idx + AW'(1);
                    if (clr_idx == LAST_A) begin
                        state    <= RF_RUN;
                        clr_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= RF_CLEAR;
                    clr_busy <= 1'b1;
                    clr_idx  <= '0;
                end
            endcase
        end
    end

    assign wa_ok = wa_en && (wa_addr != ZERO_A) && !((CONST_EN != 0) && (wa_addr == CONST_A));
    assign wb_ok = wb_en && (wb_addr != ZERO_A) && !((CONST_EN != 0) && (wb_addr == CONST_A));

    // The sweep keeps clearing even while rst is held; B is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (state == RF_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (!rst) begin
            if (wa_ok) mem[wa_addr] <= wa_data;
            if (wb_ok) mem[wb_addr] <= wb_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rdport #(
            .WIDTH    (WIDTH),
            .AW       (AW),
            .CONST_EN (CONST_EN),
            .CONST_IDX(CONST_IDX),
            .CONST_VAL(CONST_VAL)
        ) u_rdport (
            .busy    (clr_busy),
            .addr    (rd_addr[i*AW +: AW]),
            .wa_en   (wa_en),
            .wa_addr (wa_addr),
            .wa_data (wa_data),
            .wb_en   (wb_en),
            .wb_addr (wb_addr),
            .wb_data (wb_data),
            .mem_data(mem[rd_addr[i*AW +: AW]]),
            .data    (rd_data[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table for write/bypass/read priority,
// hand sequences for the clear sweep, and a 3-port 64-bit 32-deep build.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        clr_req = 1'b0;
    logic        clr_busy;
    logic        wa_en = 1'b0, wb_en = 1'b0;
    logic [3:0]  wa_addr = '0, wb_addr = '0;
    logic [31:0] wa_data = '0, wb_data = '0;
    logic [7:0]  rd_addr = '0;
    logic [63:0] rd_data;

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(clr_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    logic         clr_req2 = 1'b0;
    logic         clr_busy2;
    logic         wa_en2 = 1'b0, wb_en2 = 1'b0;
    logic [4:0]   wa_addr2 = '0, wb_addr2 = '0;
    logic [63:0]  wa_data2 = '0, wb_data2 = '0;
    logic [14:0]  rd_addr2 = '0;
    logic [191:0] rd_data2;

    regfile_mp #(.WIDTH(64), .DEPTH(32), .NUM_RD(3)) u_big (
        .clk(clk), .rst(rst), .clr_req(clr_req2), .clr_busy(clr_busy2),
        .wa_en(wa_en2), .wa_addr(wa_addr2), .wa_data(wa_data2),
        .wb_en(wb_en2), .wb_addr(wb_addr2), .wb_data(wb_data2),
        .rd_addr(rd_addr2), .rd_data(rd_data2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        wa_en;
        logic [3:0]  wa_addr;
        logic [31:0] wa_data;
        logic        wb_en;
        logic [3:0]  wb_addr;
        logic [31:0] wb_data;
        logic [3:0]  rd0;
        logic [3:0]  rd1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles clr_busy stays high; optionally pulses clr_req at sweep cycle req_at.
    task automatic count_busy(input int req_at, output int cnt);
        cnt = 0;
        while (clr_busy && cnt < 100) begin
            clr_req = (cnt == req_at);
            step();
            cnt++;
        end
        clr_req = 1'b0;
    endtask

    task automatic fill_index();
        for (int r = 1; r <= 14; r++) begin
            wa_en   = 1'b1;
            wa_addr = 4'(r);
            wa_data = 32'(r);
            step();
        end
        wa_en = 1'b0;
    endtask

    int cnt;

    initial begin
        vecs[0]  = '{1'b1, 4'd5,  32'h1234_5678, 1'b0, 4'd0,  32'h0,          4'd5,  4'd3,  32'h1234_5678, 32'h0};
        vecs[1]  = '{1'b0, 4'd0,  32'h0,          1'b0, 4'd0,  32'h0,          4'd5,  4'd0,  32'h1234_5678, 32'h0};
        vecs[2]  = '{1'b1, 4'd7,  32'h11,         1'b1, 4'd7,  32'h22,         4'd7,  4'd5,  32'h22,        32'h1234_5678};
        vecs[3]  = '{1'b0, 4'd0,  32'h0,          1'b0, 4'd0,  32'h0,          4'd7,  4'd15, 32'h22,        32'h1};
        vecs[4]  = '{1'b1, 4'd0,  32'hFFFF_FFFF, 1'b1, 4'd15, 32'hFFFF_FFFF, 4'd0,  4'd15, 32'h0,         32'h1};
        vecs[5]  = '{1'b0, 4'd0,  32'h0,          1'b0, 4'd0,  32'h0,          4'd0,  4'd15, 32'h0,         32'h1};
        vecs[6]  = '{1'b1, 4'd15, 32'hFFFF_FFFF, 1'b1, 4'd0,  32'hFFFF_FFFF, 4'd15, 4'd0,  32'h1,         32'h0};
        vecs[7]  = '{1'b1, 4'd3,  32'hA,          1'b1, 4'd4,  32'hB,          4'd3,  4'd4,  32'hA,         32'hB};
        vecs[8]  = '{1'b0, 4'd0,  32'h0,          1'b1, 4'd3,  32'hC,          4'd3,  4'd4,  32'hC,         32'hB};
        vecs[9]  = '{1'b1, 4'd9,  32'hD,          1'b0, 4'd0,  32'h0,          4'd9,  4'd3,  32'hD,         32'hC};
        vecs[10] = '{1'b0, 4'd0,  32'h0,          1'b0, 4'd0,  32'h0,          4'd9,  4'd7,  32'hD,         32'h22};

        // Reset sweep: 16 busy cycles, writes during busy are lost.
        #1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("busy_after_rst", 64'(clr_busy), 64'd1);
        wa_en = 1'b1; wa_addr = 4'd3; wa_data = 32'hAAAA;
        rd_addr = {4'd15, 4'd3};
        #2;
        check("rd3_busy", 64'(rd_data[31:0]), 64'd0);
        check("rd15_busy", 64'(rd_data[63:32]), 64'd0);
        count_busy(-1, cnt);
        check("rst_busy_cycles", 64'(cnt), 64'd16);
        wa_en = 1'b0;
        rd_addr = {4'd0, 4'd3};
        #2;
        check("rd3_lost", 64'(rd_data[31:0]), 64'd0);

        foreach (vecs[k]) begin
            wa_en = vecs[k].wa_en; wa_addr = vecs[k].wa_addr; wa_data = vecs[k].wa_data;
            wb_en = vecs[k].wb_en; wb_addr = vecs[k].wb_addr; wb_data = vecs[k].wb_data;
            rd_addr = {vecs[k].rd1, vecs[k].rd0};
            #2;
            check($sformatf("vec%0d_p0", k), 64'(rd_data[31:0]), 64'(vecs[k].exp0));
            check($sformatf("vec%0d_p1", k), 64'(rd_data[63:32]), 64'(vecs[k].exp1));
            step();
        end
        wa_en = 1'b0; wb_en = 1'b0;

        // Soft clear; a clr_req mid-sweep must not extend it.
        fill_index();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("busy_after_clr", 64'(clr_busy), 64'd1);
        count_busy(4, cnt);
        check("clr_busy_cycles", 64'(cnt), 64'd16);
        rd_addr = {4'd14, 4'd5};
        #2;
        check("clr_rd5", 64'(rd_data[31:0]), 64'd0);
        check("clr_rd14", 64'(rd_data[63:32]), 64'd0);

        // Reset at sweep cycle 8 restarts the sweep.
        fill_index();
        rd_addr = {4'd14, 4'd1};
        #2;
        check("fill_rd1", 64'(rd_data[31:0]), 64'd1);
        check("fill_rd14", 64'(rd_data[63:32]), 64'd14);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int c = 0; c < 8; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy(-1, cnt);
        check("rst_mid_busy_cycles", 64'(cnt), 64'd16);
        for (int r = 1; r <= 13; r += 2) begin
            rd_addr = {4'(r + 1), 4'(r)};
            #2;
            check($sformatf("swept_rd%0d", r), 64'(rd_data[31:0]), 64'd0);
            check($sformatf("swept_rd%0d", r + 1), 64'(rd_data[63:32]), 64'd0);
        end

        // Wide build: three ports.
        cnt = 0;
        while (clr_busy2 && cnt < 100) begin step(); cnt++; end
        check("big_idle", 64'(clr_busy2), 64'd0);
        wa_en2 = 1'b1; wa_addr2 = 5'd1;  wa_data2 = 64'h0123_4567_89AB_CDEF;
        wb_en2 = 1'b1; wb_addr2 = 5'd31; wb_data2 = 64'hFEDC_BA98_7654_3210;
        rd_addr2 = {5'd0, 5'd31, 5'd1};
        #2;
        check("big_byp_p0", rd_data2[63:0], 64'h0123_4567_89AB_CDEF);
        check("big_byp_p1", rd_data2[127:64], 64'hFEDC_BA98_7654_3210);
        step();
        wa_en2 = 1'b0; wb_en2 = 1'b0;
        #2;
        check("big_p0", rd_data2[63:0], 64'h0123_4567_89AB_CDEF);
        check("big_p1", rd_data2[127:64], 64'hFEDC_BA98_7654_3210);
        check("big_p2", rd_data2[191:128], 64'd0);
        rd_addr2 = {5'd15, 5'd1, 5'd31};
        #2;
        check("big_const", rd_data2[191:128], 64'd1);
        check("big_swap", rd_data2[63:0], 64'hFEDC_BA98_7654_3210);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
